// File: rtl/rand_gen_pkg.sv
// rand_pkg: shared types and constants for the rand_gen range-limited random generator.
// Holds the draw FSM state encoding and the maximal-length Galois tap table.
package rand_pkg;

   // Draw FSM: IDLE waits for a request, DRAW evaluates one candidate per clock.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_DRAW = 1'b1
   } rand_state_e;

   // Maximal-length tap masks for a right-shifting Galois LFSR of 8..32 bits.
   // The mask is XORed into the shifted state whenever the bit shifted out is 1.
   function automatic logic [31:0] lfsr_taps(input int width);
      logic [31:0] taps;
      case (width)
         8:       taps = 32'h0000_00B8;
         9:       taps = 32'h0000_0110;
         10:      taps = 32'h0000_0240;
         11:      taps = 32'h0000_0500;
         12:      taps = 32'h0000_0E08;
         13:      taps = 32'h0000_1C80;
         14:      taps = 32'h0000_3802;
         15:      taps = 32'h0000_6000;
         16:      taps = 32'h0000_B400;
         17:      taps = 32'h0001_2000;
         18:      taps = 32'h0002_0400;
         19:      taps = 32'h0007_2000;
         20:      taps = 32'h0009_0000;
         21:      taps = 32'h0014_0000;
         22:      taps = 32'h0030_0000;
         23:      taps = 32'h0042_0000;
         24:      taps = 32'h00E1_0000;
         25:      taps = 32'h0120_0000;
         26:      taps = 32'h0200_0023;
         27:      taps = 32'h0400_0013;
         28:      taps = 32'h0900_0000;
         29:      taps = 32'h1400_0000;
         30:      taps = 32'h2000_0029;
         31:      taps = 32'h4800_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/rand_gen_lfsr.sv
// lfsr_galois: free-running right-shift Galois LFSR with a synchronous seed load.
// A zero load value is replaced by SEED so the register can never lock up at zero.
module lfsr_galois #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;

   // Next state: a seed load wins over the shift; otherwise shift right and fold in the taps.
   always_comb begin
      state_d = state_q;
      if (load) begin
         if (load_val == {WIDTH{1'b0}}) begin
            state_d = SEED;
         end else begin
            state_d = load_val;
         end
      end else begin
         if (state_q[0]) begin
            state_d = (state_q >> 1) ^ TAPS;
         end else begin
            state_d = state_q >> 1;
         end
      end
   end

   // State register, restarts from SEED on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/rand_gen.sv
// rand_gen: on request, draws a uniformly distributed value in [MIN, MAX] from a Galois LFSR
// using rejection sampling on the low K bits, with a forced fold-down after MAX_TRIES rejections.
// Optional feature macro: RAND_GEN_NOREPEAT_EN -- never output the same value twice in a row.
module rand_gen
   import rand_pkg::*;
#(
   parameter int                WIDTH     = 3,
   parameter int                MIN       = 1,
   parameter int                MAX       = 4,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int                MAX_TRIES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              req,
   output logic              busy,
   output logic              valid,
   output logic [WIDTH-1:0]  value
);

   localparam int                R        = MAX - MIN + 1;
   localparam int                K        = $clog2(R);
   localparam int                TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [31:0]       TAPS_ALL = lfsr_taps(LFSR_W);
   localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
   // R needs K+1 bits when it is an exact power of two.
   localparam logic [K:0]        R_K1     = R[K:0];
   localparam logic [K-1:0]      R_K      = R_K1[K-1:0];
   localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);
   localparam logic [WIDTH-1:0]  MIN_W    = MIN[WIDTH-1:0];

   rand_state_e       state_q, state_d;
   logic [TRY_W-1:0]  try_q, try_d;
   logic [WIDTH-1:0]  value_q, value_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   logic [LFSR_W-1:0] lfsr_s;
   logic [K-1:0]      cand_s;
   logic              in_range_s;
   logic [K-1:0]      fold_s;
   logic [WIDTH-1:0]  cand_val_s;
   logic [WIDTH-1:0]  base_val_s;
   logic [WIDTH-1:0]  forced_val_s;
   logic              repeat_s;
   logic              unused_lfsr_bits_s;

   lfsr_galois #(
      .WIDTH (LFSR_W),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seed_load),
      .load_val (seed_in),
      .state    (lfsr_s)
   );

   // Only the low K bits feed the candidate; the rest of the LFSR just keeps the period long.
   assign unused_lfsr_bits_s = ^lfsr_s[LFSR_W-1:K];

   // Candidate, its range test, and the fold-down used on a forced draw (2^K < 2R keeps it in range).
   always_comb begin
      cand_s     = lfsr_s[K-1:0];
      in_range_s = ({1'b0, cand_s} < R_K1);
      if (in_range_s) begin
         fold_s = cand_s;
      end else begin
         fold_s = cand_s - R_K;
      end
      cand_val_s = MIN_W + WIDTH'(cand_s);
      base_val_s = MIN_W + WIDTH'(fold_s);
   end

`ifdef RAND_GEN_NOREPEAT_EN
   localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];

   logic last_valid_q, last_valid_d;

   // Repeat detection against the held output; inactive until the first value has been produced.
   always_comb begin
      repeat_s = last_valid_q && (cand_val_s == value_q);
      if (last_valid_q && (base_val_s == value_q)) begin
         if (base_val_s == MAX_W) begin
            forced_val_s = MIN_W;
         end else begin
            forced_val_s = base_val_s + WIDTH'(1'b1);
         end
      end else begin
         forced_val_s = base_val_s;
      end
   end

   // Remember that an output exists once the first valid has been issued.
   always_comb begin
      if (valid_d) begin
         last_valid_d = 1'b1;
      end else begin
         last_valid_d = last_valid_q;
      end
   end

   // last_valid register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_valid_q <= 1'b0;
      end else begin
         last_valid_q <= last_valid_d;
      end
   end
`else
   // Without repeat suppression every in-range candidate is acceptable and folds are used as-is.
   always_comb begin
      repeat_s     = 1'b0;
      forced_val_s = base_val_s;
   end
`endif

   // Draw FSM: start on req in IDLE, accept or reject one candidate per clock while in DRAW.
   always_comb begin
      state_d = state_q;
      try_d   = try_q;
      value_d = value_q;
      valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_DRAW;
               try_d   = {TRY_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAW: begin
            if (in_range_s && !repeat_s) begin
               value_d = cand_val_s;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end else if (try_q == LAST_TRY) begin
               value_d = forced_val_s;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               try_d = try_q + TRY_W'(1'b1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_DRAW);
   end

   // FSM, try counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         try_q   <= {TRY_W{1'b0}};
         value_q <= MIN_W;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         try_q   <= try_d;
         value_q <= value_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign busy  = busy_q;
   assign valid = valid_q;
   assign value = value_q;

endmodule

// File: tb/tb_rand_gen.sv
// tb_rand_gen: scoreboard bench for rand_gen. Three instances cover the default range,
// a non-power-of-two range with immediate forced draws, and a two-value range.
// A cycle-level reference model pushes expected values; scenario tasks pop and compare.
module tb_rand_gen;

   localparam int P_MIN   [3] = '{1, 0, 1};
   localparam int P_MAX   [3] = '{4, 4, 2};
   localparam int P_TRIES [3] = '{8, 1, 8};
`ifdef RAND_GEN_NOREPEAT_EN
   localparam bit NOREP = 1'b1;
`else
   localparam bit NOREP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req       [3];
   logic        seed_load [3];
   logic [15:0] seed_in   [3];
   logic        busy      [3];
   logic        valid     [3];
   logic [2:0]  value     [3];

   int total = 0;
   int bad   = 0;

   typedef struct {
      int unsigned lfsr;
      bit          drawing;
      int          tries;
      int          val;
      bit          lv;
   } mdl_t;

   mdl_t m [3];
   int   exp_q [3][$];

   always #5 clk = ~clk;

   rand_gen #(.WIDTH(3), .MIN(1), .MAX(4), .LFSR_W(16), .SEED(16'hACE1), .MAX_TRIES(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load[0]), .seed_in(seed_in[0]),
      .req(req[0]), .busy(busy[0]), .valid(valid[0]), .value(value[0]));

   rand_gen #(.WIDTH(3), .MIN(0), .MAX(4), .LFSR_W(16), .SEED(16'hACE1), .MAX_TRIES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load[1]), .seed_in(seed_in[1]),
      .req(req[1]), .busy(busy[1]), .valid(valid[1]), .value(value[1]));

   rand_gen #(.WIDTH(3), .MIN(1), .MAX(2), .LFSR_W(16), .SEED(16'hACE1), .MAX_TRIES(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load[2]), .seed_in(seed_in[2]),
      .req(req[2]), .busy(busy[2]), .valid(valid[2]), .value(value[2]));

   function automatic int unsigned galois16(input int unsigned s);
      int unsigned n;
      n = s >> 1;
      if ((s & 32'd1) != 32'd0) n = n ^ 32'h0000_B400;
      return n & 32'h0000_FFFF;
   endfunction

   function automatic int clog2_i(input int n);
      int k;
      k = 0;
      while ((1 << k) < n) k++;
      return k;
   endfunction

   // Reference model: one step per clock edge, expected values queued on acceptance.
   always @(posedge clk or negedge rst_n) begin
      int r, k, c, v;
      bit acc;
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m[i] = '{32'h0000_ACE1, 1'b0, 0, P_MIN[i], 1'b0};
            exp_q[i].delete();
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            r   = P_MAX[i] - P_MIN[i] + 1;
            k   = clog2_i(r);
            c   = int'(m[i].lfsr & ((32'd1 << k) - 32'd1));
            acc = 1'b0;
            v   = 0;
            if (m[i].drawing) begin
               if (c < r && !(NOREP && m[i].lv && (P_MIN[i] + c == m[i].val))) begin
                  acc = 1'b1;
                  v   = P_MIN[i] + c;
               end else if (m[i].tries == P_TRIES[i] - 1) begin
                  v = P_MIN[i] + ((c >= r) ? c - r : c);
                  if (NOREP && m[i].lv && v == m[i].val) v = (v == P_MAX[i]) ? P_MIN[i] : v + 1;
                  acc = 1'b1;
               end else begin
                  m[i].tries++;
               end
               if (acc) begin
                  m[i].val     = v;
                  m[i].lv      = 1'b1;
                  m[i].drawing = 1'b0;
                  exp_q[i].push_back(v);
               end
            end else if (req[i] === 1'b1) begin
               m[i].drawing = 1'b1;
               m[i].tries   = 0;
            end
            if (seed_load[i] === 1'b1)
               m[i].lfsr = (seed_in[i] == 16'h0000) ? 32'h0000_ACE1 : {16'h0000, seed_in[i]};
            else
               m[i].lfsr = galois16(m[i].lfsr);
         end
      end
   end

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         req[i]       = 1'b0;
         seed_load[i] = 1'b0;
         seed_in[i]   = 16'h0000;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (value[i] !== 3'(P_MIN[i])) begin
            bad++; $display("FAIL reset_value[%0d]: got %0d want %0d", i, value[i], P_MIN[i]);
         end
         total++;
         if (valid[i] !== 1'b0 || busy[i] !== 1'b0) begin
            bad++; $display("FAIL reset_flags[%0d]: valid=%b busy=%b want 0 0", i, valid[i], busy[i]);
         end
      end
      total++;
      if (u_dut0.u_lfsr.state !== 16'hACE1) begin
         bad++; $display("FAIL reset_lfsr: got %h want ace1", u_dut0.u_lfsr.state);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (u_dut0.u_lfsr.state !== 16'(galois16(32'h0000_ACE1))) begin
         bad++; $display("FAIL first_shift: got %h want %h", u_dut0.u_lfsr.state, 16'(galois16(32'h0000_ACE1)));
      end
   endtask

   task automatic test_single();
      int cyc, e;
      bit seen;
      for (int t = 0; t < 6; t++) begin
         req[0] = 1'b1;
         @(negedge clk);
         req[0] = 1'b0;
         total++;
         if (busy[0] !== 1'b1) begin
            bad++; $display("FAIL single_busy: got %b want 1", busy[0]);
         end
         cyc  = 1;
         seen = 1'b0;
         while (!seen && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (valid[0] === 1'b1) seen = 1'b1;
         end
         total++;
         if (!seen || cyc < 2 || cyc > 9) begin
            bad++; $display("FAIL single_latency: got %0d cycles (seen=%b) want 2..9", cyc, seen);
         end
         if (seen) begin
            total++;
            if (exp_q[0].size() == 0) begin
               bad++; $display("FAIL single_value: valid with value %0d but none expected", value[0]);
            end else begin
               e = exp_q[0].pop_front();
               if (value[0] !== 3'(e)) begin
                  bad++; $display("FAIL single_value: got %0d want %0d", value[0], e);
               end
            end
            total++;
            if (value[0] < 3'd1 || value[0] > 3'd4) begin
               bad++; $display("FAIL single_range: got %0d want 1..4", value[0]);
            end
         end
         repeat (t) @(negedge clk);
      end
   endtask

   task automatic test_seed_load();
      int nv, e;
      req[0] = 1'b1;
      @(negedge clk);
      req[0]       = 1'b0;
      seed_load[0] = 1'b1;
      seed_in[0]   = 16'h0000;
      @(negedge clk);
      seed_load[0] = 1'b0;
      total++;
      if (u_dut0.u_lfsr.state !== 16'hACE1) begin
         bad++; $display("FAIL seed_zero: got %h want ace1", u_dut0.u_lfsr.state);
      end
      nv = 0;
      for (int c = 0; c < 11; c++) begin
         if (c > 0) @(negedge clk);
         if (valid[0] === 1'b1) begin
            nv++;
            total++;
            if (exp_q[0].size() == 0) begin
               bad++; $display("FAIL seed_value: valid with value %0d but none expected", value[0]);
            end else begin
               e = exp_q[0].pop_front();
               if (value[0] !== 3'(e)) begin
                  bad++; $display("FAIL seed_value: got %0d want %0d", value[0], e);
               end
            end
         end
      end
      total++;
      if (nv != 1) begin
         bad++; $display("FAIL seed_one_valid: got %0d valids want 1", nv);
      end
      seed_load[0] = 1'b1;
      seed_in[0]   = 16'h1234;
      @(negedge clk);
      seed_load[0] = 1'b0;
      total++;
      if (u_dut0.u_lfsr.state !== 16'h1234) begin
         bad++; $display("FAIL seed_load: got %h want 1234", u_dut0.u_lfsr.state);
      end
   endtask

   task automatic test_back_to_back();
      int last_v [2];
      int nv [2];
      int hist [5];
      int e;
      logic [2:0] prev0;
      for (int i = 0; i < 2; i++) begin last_v[i] = -100; nv[i] = 0; end
      for (int v = 0; v < 5; v++) hist[v] = 0;
      prev0  = value[0];
      req[0] = 1'b1;
      req[1] = 1'b1;
      for (int cyc = 0; cyc < 20012; cyc++) begin
         if (cyc == 20000) begin req[0] = 1'b0; req[1] = 1'b0; end
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (valid[i] === 1'b1) begin
               total++;
               if (cyc - last_v[i] < 2) begin
                  bad++; $display("FAIL b2b_gap[%0d]: got %0d cycles want >=2", i, cyc - last_v[i]);
               end
               last_v[i] = cyc;
               nv[i]++;
               total++;
               if (exp_q[i].size() == 0) begin
                  bad++; $display("FAIL b2b_value[%0d]: valid with value %0d but none expected", i, value[i]);
               end else begin
                  e = exp_q[i].pop_front();
                  if (value[i] !== 3'(e)) begin
                     bad++; $display("FAIL b2b_value[%0d]: got %0d want %0d", i, value[i], e);
                  end
               end
               if (i == 1 && value[1] < 3'd5) hist[value[1]]++;
            end else if (i == 0) begin
               total++;
               if (value[0] !== prev0) begin
                  bad++; $display("FAIL value_hold: got %0d want %0d", value[0], prev0);
               end
            end
         end
         prev0 = value[0];
      end
      for (int i = 0; i < 2; i++) begin
         total++;
         if (nv[i] < 9998 || nv[i] > 10002 || exp_q[i].size() != 0) begin
            bad++; $display("FAIL b2b_count[%0d]: got %0d valids, %0d pending want ~10000, 0", i, nv[i], exp_q[i].size());
         end
      end
      for (int v = 0; v < 5; v++) begin
         total++;
         if (hist[v] == 0) begin
            bad++; $display("FAIL b2b_hist[%0d]: got 0 hits want >0", v);
         end
      end
   endtask

   task automatic test_norepeat();
      int nv, cyc, e;
      logic [2:0] prev;
      nv     = 0;
      cyc    = 0;
      prev   = 3'd0;
      req[2] = 1'b1;
      while (nv < 1000 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (valid[2] === 1'b1) begin
            total++;
            if (exp_q[2].size() == 0) begin
               bad++; $display("FAIL norep_value: valid with value %0d but none expected", value[2]);
            end else begin
               e = exp_q[2].pop_front();
               if (value[2] !== 3'(e)) begin
                  bad++; $display("FAIL norep_value: got %0d want %0d", value[2], e);
               end
            end
`ifdef RAND_GEN_NOREPEAT_EN
            if (nv > 0) begin
               total++;
               if (value[2] === prev) begin
                  bad++; $display("FAIL norep_alternate: got %0d twice", value[2]);
               end
            end
`endif
            prev = value[2];
            nv++;
            if (nv == 1000) req[2] = 1'b0;
         end
      end
      req[2] = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (nv != 1000 || exp_q[2].size() != 0) begin
         bad++; $display("FAIL norep_count: got %0d valids, %0d pending want 1000, 0", nv, exp_q[2].size());
      end
   endtask

   task automatic test_reset_mid_draw();
      int nv;
      req[0] = 1'b1;
      @(negedge clk);
      req[0] = 1'b0;
      total++;
      if (busy[0] !== 1'b1) begin
         bad++; $display("FAIL midrst_busy: got %b want 1", busy[0]);
      end
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (valid[0] !== 1'b0 || busy[0] !== 1'b0 || value[0] !== 3'd1) begin
         bad++; $display("FAIL midrst_state: valid=%b busy=%b value=%0d want 0 0 1", valid[0], busy[0], value[0]);
      end
      rst_n = 1'b1;
      nv = 0;
      repeat (4) begin
         @(negedge clk);
         if (valid[0] === 1'b1) nv++;
      end
      total++;
      if (nv != 0 || value[0] !== 3'd1) begin
         bad++; $display("FAIL midrst_novalid: got %0d valids value=%0d want 0, 1", nv, value[0]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_seed_load();
      test_back_to_back();
      test_norepeat();
      test_reset_mid_draw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
